alu_op_issuer: RTL and testbench

//  Upstream stage of the 4-to-16 opcode decoder in the ALU datapath. Accepts 4-bit
//  ALU opcodes over a valid/ready handshake and buffers them in a small FIFO.

---
 rtl/alu_op_issuer_pkg.sv | 17 +
 rtl/alu_op_issuer_if.sv | 29 ++
 rtl/alu_op_issuer_fifo.sv | 54 +++++
 rtl/alu_op_issuer.sv | 114 +++++++++++
 tb/tb_alu_op_issuer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_issuer_pkg.sv
// Shared types and helpers for the ALU opcode issuer: opcode width, issue FSM
// states and the multi-cycle opcode classifier.
package alu_op_issuer_pkg;

  localparam int OPW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } iss_state_t;

  function automatic logic is_multi(input logic [OPW-1:0] op, input logic [OPW-1:0] base);
    return (op >= base);
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command/issue bus of the ALU opcode issuer: upstream valid/ready opcode input,
// flush, and the registered opcode stream toward the 4-to-16 decoder.
interface alu_op_issuer_if #(
  parameter int DEPTH = 4
);
  import alu_op_issuer_pkg::*;

  localparam int LW = $clog2(DEPTH + 1);

  logic           cmd_valid;
  logic [OPW-1:0] cmd_op;
  logic           cmd_ready;
  logic           flush;
  logic [OPW-1:0] op_code;
  logic           op_valid;
  logic           op_done;
  logic [LW-1:0]  level;

  modport master (
    output cmd_valid, cmd_op, flush,
    input  cmd_ready, op_code, op_valid, op_done, level
  );

  modport slave (
    input  cmd_valid, cmd_op, flush,
    output cmd_ready, op_code, op_valid, op_done, level
  );

endinterface

// File: rtl/alu_op_issuer_fifo.sv
// Small opcode FIFO with one-bit-wider pointers so occupancy is a plain subtraction;
// synchronous clear drops every queued entry.
module alu_op_issuer_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [WIDTH-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      diff_s;

  assign diff_s = wr_ptr_r - rd_ptr_r;
  assign level  = LW'(diff_s);
  assign full   = (diff_s == DEPTH[AW:0]);
  assign empty  = (diff_s == {(AW+1){1'b0}});
  assign head   = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update; the caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (clear) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Opcode issuer ahead of the ALU decoder: buffers incoming opcodes and issues them
// one at a time, holding multi-cycle opcodes and pulsing op_done on each last cycle.
module alu_op_issuer
  import alu_op_issuer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int MULTI_BASE   = 12,
  parameter int MULTI_CYCLES = 3
) (
  input  logic           clk,
  input  logic           reset,
  alu_op_issuer_if.slave bus
);
  localparam int             LW       = $clog2(DEPTH + 1);
  localparam int             CW       = $clog2(MULTI_CYCLES);
  localparam logic [OPW-1:0] BASE     = OPW'(MULTI_BASE);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(MULTI_CYCLES - 1);

  iss_state_t     state_r, next_state_s;
  logic [CW-1:0]  cnt_r, next_cnt_s;
  logic [OPW-1:0] op_code_r, next_code_s;
  logic           op_valid_r, next_valid_s;
  logic [OPW-1:0] head_s;
  logic [LW-1:0]  level_s;
  logic           full_s, empty_s, ready_s, push_s, load_s, done_s;

  assign ready_s = !full_s && !bus.flush;
  assign push_s  = bus.cmd_valid && ready_s;

  alu_op_issuer_fifo #(.WIDTH(OPW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.flush),
    .push  (push_s),
    .pop   (load_s),
    .din   (bus.cmd_op),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s),
    .head  (head_s)
  );

  // Next-state, pop and completion decode; cnt counts the HOLD cycles still to come.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_code_s  = op_code_r;
    next_valid_s = op_valid_r;
    done_s       = 1'b0;
    load_s       = 1'b0;
    if (bus.flush) begin
      next_state_s = IDLE;
      next_cnt_s   = {CW{1'b0}};
      next_valid_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:  load_s = !empty_s;
        ISSUE: begin
          done_s = 1'b1;
          load_s = !empty_s;
        end
        HOLD: begin
          if (cnt_r == {CW{1'b0}}) begin
            done_s = 1'b1;
            load_s = !empty_s;
          end else begin
            next_cnt_s = cnt_r - CW'(1'b1);
          end
        end
        default: begin
          done_s = 1'b0;
          load_s = 1'b0;
        end
      endcase
      if (load_s) begin
        next_code_s  = head_s;
        next_valid_s = 1'b1;
        if (is_multi(head_s, BASE)) begin
          next_state_s = HOLD;
          next_cnt_s   = CNT_LOAD;
        end else begin
          next_state_s = ISSUE;
        end
      end else if (done_s || state_r != HOLD) begin
        next_state_s = IDLE;
        next_valid_s = 1'b0;
      end else begin
        next_state_s = HOLD;
      end
    end
  end

  // FSM, hold counter and registered decoder-facing outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      op_code_r  <= {OPW{1'b0}};
      op_valid_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      cnt_r      <= next_cnt_s;
      op_code_r  <= next_code_s;
      op_valid_r <= next_valid_s;
    end
  end

  assign bus.cmd_ready = ready_s;
  assign bus.op_code   = op_code_r;
  assign bus.op_valid  = op_valid_r;
  assign bus.op_done   = done_s;
  assign bus.level     = level_s;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: accepted opcodes queue their expected
// (op_done, op_code) cycles; a negedge monitor pops and compares every live cycle.
module tb_alu_op_issuer;
  import alu_op_issuer_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [4:0] exp_q [$];
  logic [4:0] mon_e;

  alu_op_issuer_if #(.DEPTH(4)) bus ();

  alu_op_issuer #(.DEPTH(4), .MULTI_BASE(12), .MULTI_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected cycles: single-cycle ops finish at once, opcodes >= C take three cycles.
  task automatic expect_op(input logic [3:0] op);
    if (op >= 4'hC) begin
      exp_q.push_back({1'b0, op});
      exp_q.push_back({1'b0, op});
      exp_q.push_back({1'b1, op});
    end else begin
      exp_q.push_back({1'b1, op});
    end
  endtask

  task automatic send(input logic [3:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    chk("send_ready", int'(bus.cmd_ready), 1);
    expect_op(op);
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && (bus.op_valid || bus.level != 3'd0 || exp_q.size() != 0)) begin
      tick();
      n++;
    end
    chk(name, (n < budget) ? 1 : 0, 1);
  endtask

  // Monitor: every live, non-flushed cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      chk("done_without_valid", int'(bus.op_done & ~bus.op_valid), 0);
      if (bus.op_valid && !bus.flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got op_code %0d, expected no operation", bus.op_code);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_code", int'(bus.op_code), int'(mon_e[3:0]));
          chk("sb_done", int'(bus.op_done), int'(mon_e[4]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t4_ops [7];
    int n;
    int max_lvl;
    bit saw_full;
    t4_ops = '{4'hC, 4'hD, 4'hE, 4'hF, 4'hC, 4'hD, 4'hE};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.flush     = 1'b0;
    reset         = 1'b1;
    tick();
    tick();
    chk("rst_op_valid", int'(bus.op_valid), 0);
    chk("rst_op_code", int'(bus.op_code), 0);
    chk("rst_op_done", int'(bus.op_done), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    reset = 1'b0;
    tick();

    // T1: single op latency, no bypass
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'h3;
    expect_op(4'h3);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t1_level", int'(bus.level), 1);
    chk("t1_no_bypass", int'(bus.op_valid), 0);
    tick();
    chk("t1_valid", int'(bus.op_valid), 1);
    chk("t1_code", int'(bus.op_code), 3);
    chk("t1_done", int'(bus.op_done), 1);
    tick();
    chk("t1_valid_off", int'(bus.op_valid), 0);
    chk("t1_code_kept", int'(bus.op_code), 3);

    // T2: back-to-back single-cycle ops, no bubble
    send(4'h1);
    send(4'h2);
    chk("t2_code1", int'(bus.op_code), 1);
    send(4'h3);
    bus.cmd_valid = 1'b0;
    chk("t2_code2", int'(bus.op_code), 2);
    chk("t2_valid2", int'(bus.op_valid), 1);
    tick();
    chk("t2_code3", int'(bus.op_code), 3);
    chk("t2_valid3", int'(bus.op_valid), 1);
    tick();
    chk("t2_idle", int'(bus.op_valid), 0);

    // T3: multi-cycle D followed by single-cycle 5
    send(4'hD);
    send(4'h5);
    bus.cmd_valid = 1'b0;
    chk("t3_code_d", int'(bus.op_code), 13);
    chk("t3_first_done", int'(bus.op_done), 0);
    wait_idle("t3_drain", 20);

    // T4: fill the FIFO behind long ops; refusal only while full
    max_lvl  = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = t4_ops[i];
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
        chk("t4_refuse_only_full", int'(bus.level), 4);
        saw_full = 1'b1;
        tick();
        n++;
      end
      chk("t4_accept_in_time", (n < 50) ? 1 : 0, 1);
      expect_op(t4_ops[i]);
      tick();
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
    end
    bus.cmd_valid = 1'b0;
    chk("t4_max_level", max_lvl, 4);
    chk("t4_saw_full", int'(saw_full), 1);
    wait_idle("t4_drain", 100);

    // T5: flush on the last HOLD cycle of E with two ops queued
    send(4'hE);
    send(4'h1);
    send(4'h2);
    bus.cmd_valid = 1'b0;
    tick();
    chk("t5_level_pre", int'(bus.level), 2);
    chk("t5_code_pre", int'(bus.op_code), 14);
    bus.flush     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'h7;
    #1;
    chk("t5_done_suppressed", int'(bus.op_done), 0);
    chk("t5_ready_low", int'(bus.cmd_ready), 0);
    tick();
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_q.delete();
    chk("t5_valid_off", int'(bus.op_valid), 0);
    chk("t5_level_zero", int'(bus.level), 0);
    chk("t5_done_off", int'(bus.op_done), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stay_idle", int'(bus.op_valid), 0);
    end

    // T6: asynchronous reset in the middle of a HOLD
    send(4'hF);
    bus.cmd_valid = 1'b0;
    tick();
    chk("t6_valid_pre", int'(bus.op_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", int'(bus.op_valid), 0);
    chk("t6_async_code", int'(bus.op_code), 0);
    chk("t6_async_done", int'(bus.op_done), 0);
    chk("t6_async_level", int'(bus.level), 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    send(4'h9);
    bus.cmd_valid = 1'b0;
    wait_idle("t6_after_reset", 20);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
